lti_system_tdm: RTL and testbench
=================================

// Module: lti_system_tdm
// PURPOSE
//  Generic discrete state-space filter x+=(A*x+B*u)>>>DEL, y=C*x+D*u with NS states, NI inputs, NO outputs.
//  One time-multiplexed MAC instead of a multiplier per coefficient.
//  Coefficients are runtime-loadable through a write port. Adds saturation, state clear and an overrun flag.
//  Used wherever a controller or plant model is too large for a fully parallel multiplier array.
// PARAMETERS
//  NS    4   number of states
//  NI    1   number of inputs
//  NO    1   number of outputs
//  IW   16   input word width, signed (IW<=SW)
//  OW   16   output word width, signed
//  CW   16   coefficient width, signed, CF fractional bits
//  SW   25   quantised state/operand width
//  CF   15   coefficient fractional bits
//  DEL  10   delta-operator shift
//  K = NS+NI (columns), R = NS+NO (rows), CAW = clog2(R*K), XW = SW+CF, AW = CW+SW+clog2(K)  (derived)
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  sig_in      in   NI*IW    inputs, channel i at [i*IW +: IW]
//  ce_in       in   1        sample strobe, 1 cycle
//  sig_out     out  NO*OW    outputs, registered, held between updates
//  ce_out      out  1        result-valid pulse
//  busy        out  1        computation in progress
//  overrun     out  1        sticky: ce_in arrived while busy
//  coef_we     in   1        coefficient write strobe
//  coef_addr   in   CAW      address = row*K + col; rows 0..NS-1 = [A|B], rows NS..R-1 = [C|D]
//  coef_data   in   CW       coefficient value
//  clear_state in   1        sync: zero states, abort computation, clear overrun
// BEHAVIOUR
//  Reset (async, rst_n=0): sig_out=0, ce_out=0, busy=0, overrun=0, all states=0, all coefficients=0, FSM=IDLE.
//  FSM: IDLE -> MAC (R*K cycles) -> DRAIN (2 cycles) -> UPDATE (1 cycle) -> IDLE.
//  IDLE with ce_in=1: latch u_i (sign-extended to SW) and x_j = x_long_j[XW-1:CF]; enter MAC; busy=1 from next cycle.
//  MAC: one coefficient*operand product per cycle, row-major order; the product is registered once.
//   Per-row accumulator of AW bits, cleared at each row start.
//   Operand order per row: x_0..x_{NS-1}, then u_0..u_{NI-1}.
//  Row end, rows < NS: dx_r = acc>>>DEL (arithmetic).
//   x_long_r += dx_r, saturated to XW signed; committed in UPDATE.
//  Row end, rows >= NS: y = sat(acc>>>CF, OW); sig_out is updated in UPDATE.
//  All outputs use states latched at ce_in (pre-update).
//  Latency: ce_out is high for exactly 1 cycle, R*K+3 cycles after the edge that sampled ce_in (28 at defaults).
//   busy falls on the same edge that ce_out rises.
//  ce_in while busy: ignored, overrun<=1, current computation continues unaffected.
//  coef_we: accepted only when busy=0; ignored while busy. Addresses >= R*K are ignored.
//   A new value takes effect on the next ce_in.
//  clear_state=1: any state -> IDLE next cycle; x_long=0; overrun=0; no ce_out; sig_out and coefficients kept.
//   clear_state has priority over a same-cycle ce_in, which is dropped.
//  Reset mid-computation: immediate return to reset values; no ce_out pulse follows deassertion.
// STRUCTURE
//  Package lti_pkg holds:
//   - FSM state encodings (IDLE, MAC, DRAIN, UPDATE);
//   - function clog2;
//   - function sat(value, width) for signed saturation.
//  Sub-module lti_mac: registered signed multiplier plus accumulator with clear/enable and AW-bit output.
//  Top level holds the FSM, row/column counters, coefficient RAM (R*K x CW, sync write, comb/registered read),
//   operand mux, state bank and output registers.
// TESTING
//  1 D-passthrough: D=16384 (0.5), all others 0. u=1000 -> sig_out=500, ce_out exactly 28 cycles after ce_in.
//  2 Saturation: D=-32768, u=-32768 -> sig_out=32767 (clipped). D=16384, u=-32768 -> -16384.
//  3 Integrator: B1=32767, C1=16384, A=0, u=32767.
//   1st ce_out y=0; x_long_0=1048512. 2nd ce_out y=15 (x_0=31).
//  4 Overrun: ce_in again 5 cycles after start -> ignored, overrun=1, single ce_out at cycle 28.
//   clear_state -> overrun=0.
//  5 Abort: rst_n=0 (or clear_state=1) at cycle 10 of MAC -> busy=0, no ce_out.
//   For rst_n, sig_out=0. Next ce_in completes normally.
//  6 Write lockout: coef_we while busy -> coefficient unchanged (result matches old value). Same write when idle -> takes effect.

Source files
------------

// File: rtl/lti_pkg.sv
// Shared types and helpers for the time-multiplexed state-space filter.
//  - lti_state_e : sequencer states
//  - clog2       : ceil(log2(v)), used for derived widths
//  - sat         : signed saturation of a 64-bit value to a given width
package lti_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UPDATE = 2'd3
  } lti_state_e;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < 64'(v); p = p << 1) r++;
    return r;
  endfunction

  // Clamp a signed value into the range of a signed word of 'width' bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lti_system_tdm_if.sv
// Sample, result and coefficient-load signals of the state-space filter.
//  master : drives sig_in, ce_in, coef_we/addr/data, clear_state; observes results
//  slave  : the filter side
interface lti_system_tdm_if #(
  parameter int unsigned NI  = 1,
  parameter int unsigned NO  = 1,
  parameter int unsigned IW  = 16,
  parameter int unsigned OW  = 16,
  parameter int unsigned CW  = 16,
  parameter int unsigned CAW = 5
);
  logic [NI*IW-1:0] sig_in;
  logic             ce_in;
  logic [NO*OW-1:0] sig_out;
  logic             ce_out;
  logic             busy;
  logic             overrun;
  logic             coef_we;
  logic [CAW-1:0]   coef_addr;
  logic [CW-1:0]    coef_data;
  logic             clear_state;

  modport master (
    output sig_in, ce_in, coef_we, coef_addr, coef_data, clear_state,
    input  sig_out, ce_out, busy, overrun
  );

  modport slave (
    input  sig_in, ce_in, coef_we, coef_addr, coef_data, clear_state,
    output sig_out, ce_out, busy, overrun
  );
endinterface

// File: rtl/lti_mac.sv
// Registered signed multiplier followed by a row accumulator.
//  clk, rst_n : clock, async active-low reset
//  clr_i      : synchronous flush of the pipeline and accumulator
//  en_i       : a coef/operand pair is presented this cycle
//  first_i    : the pair is the first of a row (accumulator restarts)
//  coef_i     : CW-bit signed coefficient
//  opnd_i     : SW-bit signed operand
//  acc_o      : AW-bit running row sum, valid one cycle after the product
module lti_mac #(
  parameter int unsigned CW = 16,
  parameter int unsigned SW = 25,
  parameter int unsigned AW = 44
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 first_i,
  input  logic signed [CW-1:0] coef_i,
  input  logic signed [SW-1:0] opnd_i,
  output logic signed [AW-1:0] acc_o
);
  localparam int unsigned PW = CW + SW;

  logic signed [PW-1:0] prod_q;
  logic                 vld_q;
  logic                 first_q;
  logic signed [AW-1:0] acc_q;

  // Product stage, then accumulate; a row start overwrites the old sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
    end else if (clr_i) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      vld_q   <= en_i;
      first_q <= en_i & first_i;
      if (en_i) prod_q <= PW'(coef_i) * PW'(opnd_i);
      if (vld_q) acc_q <= (first_q ? {AW{1'b0}} : acc_q) + AW'(prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/lti_system_tdm.sv
// Discrete state-space filter x += (A*x + B*u) >>> DEL, y = C*x + D*u,
// evaluated on a single time-multiplexed MAC, one coefficient per cycle.
//  clk   : rising-edge clock
//  rst_n : async active-low reset
//  bus   : slave side of lti_system_tdm_if (samples, results, status,
//          coefficient write port, clear_state)
module lti_system_tdm
  import lti_pkg::*;
#(
  parameter int unsigned NS  = 4,
  parameter int unsigned NI  = 1,
  parameter int unsigned NO  = 1,
  parameter int unsigned IW  = 16,
  parameter int unsigned OW  = 16,
  parameter int unsigned CW  = 16,
  parameter int unsigned SW  = 25,
  parameter int unsigned CF  = 15,
  parameter int unsigned DEL = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  lti_system_tdm_if.slave bus
);
  localparam int unsigned K   = NS + NI;
  localparam int unsigned R   = NS + NO;
  localparam int unsigned N   = R * K;
  localparam int unsigned CAW = clog2(N);
  localparam int unsigned XW  = SW + CF;
  localparam int unsigned AW  = CW + SW + clog2(K);
  localparam int unsigned RW  = (clog2(R) == 0) ? 1 : clog2(R);
  localparam int unsigned KW  = (clog2(K) == 0) ? 1 : clog2(K);

  lti_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] col_q, col_d;
  logic          drn_q, drn_d;
  logic          busy_q, busy_d;
  logic          ce_out_q, ce_out_d;
  logic          overrun_q, overrun_d;
  logic          start_c, issue_c, commit_c;

  logic signed [CW-1:0] coef_q  [N];
  logic signed [XW-1:0] x_long_q[NS];
  logic signed [XW-1:0] x_nxt_q [NS];
  logic signed [SW-1:0] x_op_q  [NS];
  logic signed [SW-1:0] u_op_q  [NI];
  logic signed [OW-1:0] y_stg_q [NO];
  logic [NO*OW-1:0]     sig_out_q;

  logic [CAW-1:0]       addr_c;
  logic signed [CW-1:0] coef_c;
  logic signed [SW-1:0] opnd_c;
  logic                 first_c, last_c;
  logic signed [AW-1:0] acc_w;
  logic                 last1_q, last2_q;
  logic [RW-1:0]        row1_q, row2_q;

  // Sequencer next state; clear_state overrides everything, including ce_in.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    drn_d     = drn_q;
    overrun_d = overrun_q;
    start_c   = 1'b0;
    issue_c   = 1'b0;
    commit_c  = 1'b0;
    if (bus.ce_in && busy_q) overrun_d = 1'b1;
    if (bus.clear_state) begin
      state_d   = ST_IDLE;
      row_d     = '0;
      col_d     = '0;
      drn_d     = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ce_in) begin
            start_c = 1'b1;
            state_d = ST_MAC;
            row_d   = '0;
            col_d   = '0;
          end
        end
        ST_MAC: begin
          issue_c = 1'b1;
          if (col_q == KW'(K - 1)) begin
            col_d = '0;
            if (row_q == RW'(R - 1)) begin
              row_d   = '0;
              drn_d   = 1'b0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // Two cycles let the last product reach the accumulator and be scaled.
        ST_DRAIN: begin
          drn_d = 1'b1;
          if (drn_q) state_d = ST_UPDATE;
        end
        ST_UPDATE: begin
          commit_c = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d   = (state_d != ST_IDLE);
    ce_out_d = commit_c;
  end

  // Sequencer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      drn_q     <= 1'b0;
      busy_q    <= 1'b0;
      ce_out_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      drn_q     <= drn_d;
      busy_q    <= busy_d;
      ce_out_q  <= ce_out_d;
      overrun_q <= overrun_d;
    end
  end

  // Coefficient RAM: writes only while idle and only to valid addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < N; a++) coef_q[a] <= '0;
    end else if (bus.coef_we && !busy_q && (32'(bus.coef_addr) < N)) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  assign addr_c  = CAW'(32'(row_q) * K + 32'(col_q));
  assign coef_c  = coef_q[addr_c];
  assign first_c = (col_q == '0);
  assign last_c  = (col_q == KW'(K - 1));

  // Operand mux: states first, then inputs, matching the column order.
  always_comb begin
    opnd_c = '0;
    for (int unsigned j = 0; j < NS; j++)
      if (32'(col_q) == j) opnd_c = x_op_q[j];
    for (int unsigned i = 0; i < NI; i++)
      if (32'(col_q) == NS + i) opnd_c = u_op_q[i];
  end

  // Snapshot quantised states and inputs so the whole pass sees one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NS; j++) x_op_q[j] <= '0;
      for (int unsigned i = 0; i < NI; i++) u_op_q[i] <= '0;
    end else if (start_c) begin
      for (int unsigned j = 0; j < NS; j++) x_op_q[j] <= x_long_q[j][XW-1:CF];
      for (int unsigned i = 0; i < NI; i++)
        u_op_q[i] <= SW'(signed'(bus.sig_in[i*IW +: IW]));
    end
  end

  lti_mac #(
    .CW (CW),
    .SW (SW),
    .AW (AW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (bus.clear_state),
    .en_i    (issue_c),
    .first_i (first_c),
    .coef_i  (coef_c),
    .opnd_i  (opnd_c),
    .acc_o   (acc_w)
  );

  // Row tags follow the product and accumulate stages of the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      row1_q  <= '0;
      row2_q  <= '0;
    end else if (bus.clear_state) begin
      last1_q <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      last1_q <= issue_c & last_c;
      row1_q  <= row_q;
      last2_q <= last1_q;
      row2_q  <= row1_q;
    end
  end

  // Row end: stage next state or output; nothing visible changes until commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NS; r++) x_nxt_q[r] <= '0;
      for (int unsigned o = 0; o < NO; o++) y_stg_q[o] <= '0;
    end else if (last2_q) begin
      for (int unsigned r = 0; r < NS; r++)
        if (32'(row2_q) == r)
          x_nxt_q[r] <= XW'(sat(64'(x_long_q[r]) + 64'(acc_w >>> DEL), XW));
      for (int unsigned o = 0; o < NO; o++)
        if (32'(row2_q) == NS + o)
          y_stg_q[o] <= OW'(sat(64'(acc_w >>> CF), OW));
    end
  end

  // State bank and outputs: clear zeroes states, commit applies a full pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NS; r++) x_long_q[r] <= '0;
      sig_out_q <= '0;
    end else if (bus.clear_state) begin
      for (int unsigned r = 0; r < NS; r++) x_long_q[r] <= '0;
    end else if (commit_c) begin
      for (int unsigned r = 0; r < NS; r++) x_long_q[r] <= x_nxt_q[r];
      for (int unsigned o = 0; o < NO; o++) sig_out_q[o*OW +: OW] <= y_stg_q[o];
    end
  end

  assign bus.sig_out = sig_out_q;
  assign bus.ce_out  = ce_out_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_lti_system_tdm.sv
// Self-checking bench for lti_system_tdm at default parameters.
// Expected values come from a plain-arithmetic state-space model.
module tb_lti_system_tdm;
  localparam int NS = 4, NI = 1, K = 5, R = 5, N = 25;
  localparam int DEL = 10, CF = 15, XW = 40, LAT = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cm[N];
  longint xl[NS];
  int last_y = 0;

  lti_system_tdm_if bus ();
  lti_system_tdm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int a = 0; a < N; a++) cm[a] = 0;
    for (int j = 0; j < NS; j++) xl[j] = 0;
  endtask

  function automatic longint sat_m(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // One sample of the reference filter: returns y and advances the states.
  task automatic model_step(input int u, output int y);
    longint op[K];
    longint nx[NS];
    longint acc;
    y = 0;
    for (int j = 0; j < NS; j++) op[j] = xl[j] >>> CF;
    for (int i = 0; i < NI; i++) op[NS+i] = longint'(u);
    for (int r = 0; r < R; r++) begin
      acc = 0;
      for (int c = 0; c < K; c++) acc += longint'(cm[r*K+c]) * op[c];
      if (r < NS) nx[r] = sat_m(xl[r] + (acc >>> DEL), XW);
      else y = int'(sat_m(acc >>> CF, 16));
    end
    for (int j = 0; j < NS; j++) xl[j] = nx[j];
    last_y = y;
  endtask

  task automatic write_coef(input int a, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 5'(a);
    bus.coef_data = 16'(v);
    cyc();
    bus.coef_we = 1'b0;
    cm[a] = v;
  endtask

  task automatic pulse_clear();
    bus.clear_state = 1'b1;
    cyc();
    bus.clear_state = 1'b0;
    for (int j = 0; j < NS; j++) xl[j] = 0;
  endtask

  // Issue one sample and wait (bounded) for ce_out; lat = -1 on timeout.
  task automatic run_sample(input int u, output logic [15:0] y, output int lat,
                            output logic b0, output logic bend);
    bus.sig_in = 16'(u);
    bus.ce_in  = 1'b1;
    cyc();
    bus.ce_in = 1'b0;
    b0   = bus.busy;
    lat  = -1;
    bend = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      cyc();
      if (bus.ce_out) begin
        lat  = n;
        bend = bus.busy;
        break;
      end
    end
    y = bus.sig_out;
  endtask

  task automatic test_reset();
    logic [15:0] y; int lat; logic b0, be; int ey;
    bus.sig_in = '0; bus.ce_in = 0; bus.coef_we = 0; bus.coef_addr = '0;
    bus.coef_data = '0; bus.clear_state = 0;
    rst_n = 1'b0;
    repeat (3) cyc();
    checks++; if (bus.sig_out !== 16'd0) begin errors++; $display("FAIL rst_sig_out got %0d want 0", bus.sig_out); end
    checks++; if (bus.ce_out !== 1'b0) begin errors++; $display("FAIL rst_ce_out got %b want 0", bus.ce_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", bus.overrun); end
    rst_n = 1'b1;
    cyc();
    model_reset();
    run_sample(1234, y, lat, b0, be);
    model_step(1234, ey);
    checks++; if (y !== 16'(ey)) begin errors++; $display("FAIL zero_coef_y got %0d want %0d", $signed(y), ey); end
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", b0); end
  endtask

  task automatic test_passthrough();
    logic [15:0] y; int lat; logic b0, be; int ey;
    write_coef(24, 16384);
    run_sample(1000, y, lat, b0, be);
    model_step(1000, ey);
    checks++; if (y !== 16'd500) begin errors++; $display("FAIL pass_y got %0d want 500", $signed(y)); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL pass_latency got %0d want %0d", lat, LAT); end
    checks++; if (be !== 1'b0) begin errors++; $display("FAIL pass_busy_at_ce_out got %b want 0", be); end
    cyc();
    checks++; if (bus.ce_out !== 1'b0) begin errors++; $display("FAIL pass_ce_out_width got %b want 0", bus.ce_out); end
  endtask

  task automatic test_saturation();
    logic [15:0] y; int lat; logic b0, be; int ey;
    write_coef(24, -32768);
    run_sample(-32768, y, lat, b0, be);
    model_step(-32768, ey);
    checks++; if (y !== 16'sd32767) begin errors++; $display("FAIL sat_pos got %0d want 32767", $signed(y)); end
    write_coef(24, 16384);
    run_sample(-32768, y, lat, b0, be);
    model_step(-32768, ey);
    checks++; if (y !== 16'(-16384)) begin errors++; $display("FAIL sat_neg_half got %0d want -16384", $signed(y)); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL sat_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_write_lockout();
    logic [15:0] y; int lat; logic b0, be; int ey;
    bus.sig_in = 16'd4000;
    bus.ce_in  = 1'b1;
    cyc();
    bus.ce_in = 1'b0;
    repeat (3) cyc();
    bus.coef_we = 1'b1; bus.coef_addr = 5'd24; bus.coef_data = 16'd8192;
    cyc();
    bus.coef_we = 1'b0;
    lat = -1;
    for (int n = 5; n <= 60; n++) begin
      cyc();
      if (bus.ce_out) begin lat = n; break; end
    end
    model_step(4000, ey);
    checks++; if (bus.sig_out !== 16'(ey)) begin errors++; $display("FAIL lockout_busy_write got %0d want %0d", $signed(bus.sig_out), ey); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL lockout_latency got %0d want %0d", lat, LAT); end
    write_coef(24, 8192);
    run_sample(4000, y, lat, b0, be);
    model_step(4000, ey);
    checks++; if (y !== 16'd1000) begin errors++; $display("FAIL lockout_idle_write got %0d want 1000", $signed(y)); end
  endtask

  task automatic test_integrator();
    logic [15:0] y; int lat; logic b0, be; int ey;
    write_coef(24, 0);
    write_coef(4, 32767);
    write_coef(20, 16384);
    pulse_clear();
    run_sample(32767, y, lat, b0, be);
    model_step(32767, ey);
    checks++; if (y !== 16'd0) begin errors++; $display("FAIL integ_first got %0d want 0", $signed(y)); end
    checks++; if (xl[0] != 64'd1048512) begin errors++; $display("FAIL integ_model_state got %0d want 1048512", xl[0]); end
    run_sample(32767, y, lat, b0, be);
    model_step(32767, ey);
    checks++; if (y !== 16'd15) begin errors++; $display("FAIL integ_second got %0d want 15", $signed(y)); end
  endtask

  task automatic test_overrun();
    int lat; int ey; int extra;
    bus.sig_in = 16'sd20000;
    bus.ce_in  = 1'b1;
    cyc();
    bus.ce_in = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin bus.ce_in = 1'b1; bus.sig_in = 16'd77; end
      cyc();
      bus.ce_in = 1'b0;
      if (n == 5) begin
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", bus.overrun); end
      end
      if (bus.ce_out) begin lat = n; break; end
    end
    model_step(20000, ey);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL overrun_latency got %0d want %0d", lat, LAT); end
    checks++; if (bus.sig_out !== 16'(ey)) begin errors++; $display("FAIL overrun_result got %0d want %0d", $signed(bus.sig_out), ey); end
    extra = 0;
    for (int n = 0; n < 40; n++) begin cyc(); if (bus.ce_out) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL overrun_extra_ce_out got %0d want 0", extra); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", bus.overrun); end
    pulse_clear();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", bus.overrun); end
  endtask

  task automatic test_clear_abort();
    int pulses;
    bus.sig_in = 16'sd12345;
    bus.ce_in  = 1'b1;
    cyc();
    bus.ce_in = 1'b0;
    repeat (10) cyc();
    bus.clear_state = 1'b1;
    cyc();
    bus.clear_state = 1'b0;
    for (int j = 0; j < NS; j++) xl[j] = 0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_abort_busy got %b want 0", bus.busy); end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin cyc(); if (bus.ce_out) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL clr_abort_ce_out got %0d want 0", pulses); end
    checks++; if (bus.sig_out !== 16'(last_y)) begin errors++; $display("FAIL clr_abort_sig_kept got %0d want %0d", $signed(bus.sig_out), last_y); end
    bus.ce_in = 1'b1; bus.clear_state = 1'b1;
    cyc();
    bus.ce_in = 1'b0; bus.clear_state = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr_priority_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] y; int lat; logic b0, be; int ey; int pulses;
    bus.sig_in = 16'sd9999;
    bus.ce_in  = 1'b1;
    cyc();
    bus.ce_in = 1'b0;
    repeat (10) cyc();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy got %b want 0", bus.busy); end
    checks++; if (bus.sig_out !== 16'd0) begin errors++; $display("FAIL rst_abort_sig_out got %0d want 0", $signed(bus.sig_out)); end
    cyc();
    rst_n = 1'b1;
    model_reset();
    pulses = 0;
    for (int n = 0; n < 40; n++) begin cyc(); if (bus.ce_out) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_abort_ce_out got %0d want 0", pulses); end
    write_coef(24, 16384);
    run_sample(-2000, y, lat, b0, be);
    model_step(-2000, ey);
    checks++; if (y !== 16'(-1000)) begin errors++; $display("FAIL rst_abort_next got %0d want -1000", $signed(y)); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_abort_next_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [15:0] y; int lat; logic b0, be; int ey; int u; int v;
    for (int a = 0; a < N; a++) begin
      // Keep A modest so the states wander rather than pin at the rails at once.
      if (a < NS * K && (a % K) < NS) v = int'($urandom_range(8191)) - 4096;
      else v = int'($urandom_range(65535)) - 32768;
      write_coef(a, v);
    end
    for (int s = 0; s < 6; s++) begin
      u = int'($urandom_range(65535)) - 32768;
      run_sample(u, y, lat, b0, be);
      model_step(u, ey);
      checks++; if (y !== 16'(ey)) begin errors++; $display("FAIL rand_y[%0d] got %0d want %0d", s, $signed(y), ey); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", s, lat, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_write_lockout();
    test_integrator();
    test_overrun();
    test_clear_abort();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
